// File: rtl/led_colour_controller.sv
// Accumulates rotary pulses into R/G/B channels and hands GRB snapshots to the serialiser.
// Build option WRAP_AROUND_EN: channels wrap modulo 256 instead of saturating.
module led_colour_controller #(
    parameter int unsigned    STEP       = 8,
    parameter logic [7:0]     INIT_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        rotation_up,
    input  logic        rotation_dn,
    input  logic        channel_next,
    input  logic        colour_ready,
    output logic        colour_valid,
    output logic [23:0] colour_out,
    output logic [1:0]  channel_sel
);

    localparam logic [7:0] STEP_B = STEP[7:0];

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q, state_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]  sel_q, sel_d;
    logic        dirty_q, dirty_d;
    logic        valid_q, valid_d;
    logic [23:0] out_q, out_d;

    logic [7:0]  cur_val, new_val;
    logic [8:0]  sum9, diff9;
    logic        changed;

    always_comb begin
        case (sel_q)
            2'd1:    cur_val = g_q;
            2'd2:    cur_val = b_q;
            default: cur_val = r_q;
        endcase
        sum9    = {1'b0, cur_val} + {1'b0, STEP_B};
        diff9   = {1'b0, cur_val} - {1'b0, STEP_B};
        new_val = cur_val;
        if (rotation_up && !rotation_dn) begin
`ifdef WRAP_AROUND_EN
            new_val = sum9[7:0];
`else
            new_val = sum9[8] ? 8'hFF : sum9[7:0];
`endif
        end else if (rotation_dn && !rotation_up) begin
`ifdef WRAP_AROUND_EN
            new_val = diff9[7:0];
`else
            new_val = diff9[8] ? 8'h00 : diff9[7:0];
`endif
        end
        changed = (new_val != cur_val);
    end

    always_comb begin
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
        sel_d = sel_q;
        case (sel_q)
            2'd1:    g_d = new_val;
            2'd2:    b_d = new_val;
            default: r_d = new_val;
        endcase
        if (channel_next) begin
            sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
        end
    end

    // Snapshot always takes the pre-update values; a concurrent change keeps dirty set.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        out_d   = out_q;
        dirty_d = dirty_q | changed;
        case (state_q)
            IDLE: begin
                if (dirty_q) begin
                    out_d   = {g_q, r_q, b_q};
                    valid_d = 1'b1;
                    dirty_d = changed;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (valid_q && colour_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            r_q     <= INIT_VALUE;
            g_q     <= INIT_VALUE;
            b_q     <= INIT_VALUE;
            sel_q   <= 2'd0;
            dirty_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= 24'h0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            dirty_q <= dirty_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign colour_valid = valid_q;
    assign colour_out   = out_q;
    assign channel_sel  = sel_q;

endmodule

// File: tb/tb_led_colour_controller.sv
// Scoreboard bench for led_colour_controller (STEP=8, INIT_VALUE=8'h10).
module tb_led_colour_controller;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        rotation_up = 1'b0;
    logic        rotation_dn = 1'b0;
    logic        channel_next = 1'b0;
    logic        colour_ready = 1'b0;
    logic        colour_valid;
    logic [23:0] colour_out;
    logic [1:0]  channel_sel;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [23:0] exp_q[$];
    logic        prev_valid = 1'b0;
    logic [23:0] prev_out = 24'h0;

    led_colour_controller #(.STEP(8), .INIT_VALUE(8'h10)) dut (
        .clk          (clk),
        .res_n        (res_n),
        .rotation_up  (rotation_up),
        .rotation_dn  (rotation_dn),
        .channel_next (channel_next),
        .colour_ready (colour_ready),
        .colour_valid (colour_valid),
        .colour_out   (colour_out),
        .channel_sel  (channel_sel)
    );

    always #12 clk = ~clk;

    // Monitor: every new frame (rising colour_valid) is matched against the queue head.
    always @(negedge clk) begin
        if (colour_valid && !prev_valid) begin
            frames++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame: got %h, none expected", colour_out);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (colour_out !== e) begin
                    errors++;
                    $display("FAIL frame: got %h, expected %h", colour_out, e);
                end
            end
        end else if (colour_valid && prev_valid) begin
            checks++;
            if (colour_out !== prev_out) begin
                errors++;
                $display("FAIL frame_stable: got %h, expected %h", colour_out, prev_out);
            end
        end
        prev_valid = colour_valid;
        prev_out   = colour_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic up, input logic dn, input logic nx);
        rotation_up  = up;
        rotation_dn  = dn;
        channel_next = nx;
        @(negedge clk);
        rotation_up  = 1'b0;
        rotation_dn  = 1'b0;
        channel_next = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (colour_valid) break;
            @(negedge clk);
        end
        checks++;
        if (!colour_valid) begin
            errors++;
            $display("FAIL %s_timeout: colour_valid still 0 after %0d cycles", name, max);
        end
    endtask

    task automatic expect_no_frame(input string name);
        int fc;
        fc = frames;
        idle(6);
        chk(name, frames, fc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r, r_fin, b_fin;
        idle(3);
        chk("reset_valid", colour_valid, 0);
        chk("reset_out", colour_out, 24'h0);
        chk("reset_sel", channel_sel, 0);

        // First frame after reset; one-cycle ready accepts it, nothing follows.
        exp_q.push_back(24'h101010);
        res_n = 1'b1;
        wait_valid("init_frame", 4);
        idle(3);
        chk("init_hold", colour_valid, 1);
        colour_ready = 1'b1;
        @(negedge clk);
        colour_ready = 1'b0;
        chk("init_accept", colour_valid, 0);
        expect_no_frame("init_no_refire");
        colour_ready = 1'b1;

        // One pulse on R, latency n+2.
        exp_q.push_back(24'h101810);
        pulse(1, 0, 0);
        chk("lat_n1", colour_valid, 0);
        @(negedge clk);
        chk("lat_n2", colour_valid, 1);
        idle(3);

        // Ramp R up to F8, then hit the top limit.
        r = 8'h18;
        for (int i = 0; i < 28; i++) begin
            r = r + 8'h08;
            exp_q.push_back({8'h10, r, 8'h10});
            pulse(1, 0, 0);
            idle(3);
        end
`ifdef WRAP_AROUND_EN
        exp_q.push_back(24'h100010);
        pulse(1, 0, 0);
        idle(3);
        exp_q.push_back(24'h100810);
        pulse(1, 0, 0);
        idle(3);
        r_fin = 8'h08;
`else
        exp_q.push_back(24'h10FF10);
        pulse(1, 0, 0);
        idle(3);
        pulse(1, 0, 0);
        expect_no_frame("sat_up_no_frame");
        r_fin = 8'hFF;
`endif

        // Channel select sequence.
        pulse(0, 0, 1); chk("sel_1", channel_sel, 1);
        pulse(0, 0, 1); chk("sel_2", channel_sel, 2);
        pulse(0, 0, 1); chk("sel_0", channel_sel, 0);
        pulse(0, 0, 1); chk("sel_1b", channel_sel, 1);

        // Coalescing on G while the serialiser stalls.
        colour_ready = 1'b0;
        idle(2);
        exp_q.push_back({8'h18, r_fin, 8'h10});
        pulse(1, 0, 0);
        wait_valid("coal_first", 4);
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0, 0);
            @(negedge clk);
        end
        chk("coal_held", colour_out, {8'h18, r_fin, 8'h10});
        exp_q.push_back({8'h30, r_fin, 8'h10});
        colour_ready = 1'b1;
        idle(3);
        expect_no_frame("coal_single");

        pulse(1, 1, 0);
        expect_no_frame("up_dn_cancel");

        // B down to the bottom limit.
        pulse(0, 0, 1);
        chk("sel_b", channel_sel, 2);
        idle(2);
        exp_q.push_back({8'h30, r_fin, 8'h08});
        pulse(0, 1, 0); idle(3);
        exp_q.push_back({8'h30, r_fin, 8'h00});
        pulse(0, 1, 0); idle(3);
`ifdef WRAP_AROUND_EN
        exp_q.push_back({8'h30, r_fin, 8'hF8});
        pulse(0, 1, 0); idle(3);
        b_fin = 8'h00;
`else
        pulse(0, 1, 0);
        expect_no_frame("sat_dn_no_frame");
        b_fin = 8'h08;
`endif

        // Rotation and channel advance together: old channel updated.
        exp_q.push_back({8'h30, r_fin, b_fin});
        pulse(1, 0, 1);
        chk("next_with_up_sel", channel_sel, 0);
        idle(4);

        // Reset in the middle of a pending transfer.
        colour_ready = 1'b0;
        exp_q.push_back({8'h30, r_fin - 8'h08, b_fin});
        pulse(0, 1, 0);
        wait_valid("pre_reset_frame", 4);
        idle(2);
        exp_q.push_back(24'h101010);
        res_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", colour_valid, 0);
        chk("rst_mid_sel", channel_sel, 0);
        res_n = 1'b1;
        wait_valid("reset_refire", 4);
        colour_ready = 1'b1;
        idle(6);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
